// File: rtl/sync_arith_arbiter.sv
// Round-robin arbiter that feeds two requesters, one transaction at a time, into a
// shared fixed-latency arithmetic unit and returns the captured result to the winner.
module sync_arith_arbiter #(
  parameter int BITS    = 32,
  parameter int LATENCY = 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_req_valid_0,
  input  logic            i_req_valid_1,
  output logic            o_req_ready_0,
  output logic            o_req_ready_1,
  input  logic [BITS-1:0] i_arg_A_0,
  input  logic [BITS-1:0] i_arg_B_0,
  input  logic [BITS-1:0] i_arg_A_1,
  input  logic [BITS-1:0] i_arg_B_1,
  input  logic [1:0]      i_op_0,
  input  logic [1:0]      i_op_1,
  output logic            o_rsp_valid_0,
  output logic            o_rsp_valid_1,
  input  logic            i_rsp_ready_0,
  input  logic            i_rsp_ready_1,
  output logic [BITS-1:0] o_rsp_result,
  output logic [3:0]      o_rsp_status,
  output logic [BITS-1:0] o_alu_arg_A,
  output logic [BITS-1:0] o_alu_arg_B,
  output logic [1:0]      o_alu_op,
  input  logic [BITS-1:0] i_alu_result,
  input  logic [3:0]      i_alu_status,
  output logic            o_busy,
  output logic            o_grant_id,
  output logic [15:0]     o_txn_count
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_LOAD = 4'(LATENCY);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            prio_q, prio_d;
  logic            grant_q, grant_d;
  logic [BITS-1:0] alu_a_q, alu_a_d;
  logic [BITS-1:0] alu_b_q, alu_b_d;
  logic [1:0]      alu_op_q, alu_op_d;
  logic [BITS-1:0] res_q, res_d;
  logic [3:0]      st_q, st_d;
  logic [15:0]     txn_q, txn_d;

  logic win_0, win_1, idle_ok, accept, rsp_take;

  // prio_q names the requester favoured on a tie; a lone requester always wins.
  assign win_1   = i_req_valid_1 && (!i_req_valid_0 || prio_q);
  assign win_0   = i_req_valid_0 && !win_1;
  assign idle_ok = (state_q == IDLE) && i_reset;

  assign o_req_ready_0 = idle_ok && win_0;
  assign o_req_ready_1 = idle_ok && win_1;
  assign accept        = o_req_ready_0 || o_req_ready_1;
  assign rsp_take      = grant_q ? i_rsp_ready_1 : i_rsp_ready_0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prio_d   = prio_q;
    grant_d  = grant_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    res_d    = res_q;
    st_d     = st_q;
    txn_d    = txn_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          grant_d  = win_1;
          alu_a_d  = win_1 ? i_arg_A_1 : i_arg_A_0;
          alu_b_d  = win_1 ? i_arg_B_1 : i_arg_B_0;
          alu_op_d = win_1 ? i_op_1 : i_op_0;
          cnt_d    = LAT_LOAD;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // cnt_q == 1 marks the edge LATENCY cycles after the accept.
        if (cnt_q <= 4'd1) begin
          res_d   = i_alu_result;
          st_d    = i_alu_status;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_take) begin
          txn_d   = txn_q + 16'd1;
          prio_d  = ~grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prio_q   <= 1'b0;
      grant_q  <= 1'b0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      res_q    <= '0;
      st_q     <= '0;
      txn_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prio_q   <= prio_d;
      grant_q  <= grant_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      res_q    <= res_d;
      st_q     <= st_d;
      txn_q    <= txn_d;
    end
  end

  assign o_rsp_valid_0 = (state_q == RESP) && !grant_q;
  assign o_rsp_valid_1 = (state_q == RESP) && grant_q;
  assign o_rsp_result  = res_q;
  assign o_rsp_status  = st_q;
  assign o_alu_arg_A   = alu_a_q;
  assign o_alu_arg_B   = alu_b_q;
  assign o_alu_op      = alu_op_q;
  assign o_busy        = (state_q != IDLE);
  assign o_grant_id    = grant_q;
  assign o_txn_count   = txn_q;

endmodule

// File: tb/tb_sync_arith_arbiter.sv
// Scoreboard bench: instance 0 runs with LATENCY=1, instance 1 with LATENCY=4.
module tb_sync_arith_arbiter;

  typedef struct packed {
    logic        gid;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] res;
    logic [3:0]  st;
  } exp_t;

  logic        clk;
  logic        rst_n      [2];
  logic        req_valid0 [2];
  logic        req_valid1 [2];
  logic        req_ready0 [2];
  logic        req_ready1 [2];
  logic [31:0] arg_a0     [2];
  logic [31:0] arg_b0     [2];
  logic [31:0] arg_a1     [2];
  logic [31:0] arg_b1     [2];
  logic [1:0]  op0        [2];
  logic [1:0]  op1        [2];
  logic        rsp_valid0 [2];
  logic        rsp_valid1 [2];
  logic        rsp_ready0 [2];
  logic        rsp_ready1 [2];
  logic [31:0] rsp_result [2];
  logic [3:0]  rsp_status [2];
  logic [31:0] alu_a      [2];
  logic [31:0] alu_b      [2];
  logic [1:0]  alu_op     [2];
  logic [31:0] alu_result [2];
  logic [3:0]  alu_status [2];
  logic        busy       [2];
  logic        grant      [2];
  logic [15:0] txn_count  [2];

  logic [15:0] txn_exp [2];
  exp_t        sb0[$];
  exp_t        sb1[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    sync_arith_arbiter #(.BITS(32), .LATENCY(gi == 0 ? 1 : 4)) u_dut (
      .i_clk(clk), .i_reset(rst_n[gi]),
      .i_req_valid_0(req_valid0[gi]), .i_req_valid_1(req_valid1[gi]),
      .o_req_ready_0(req_ready0[gi]), .o_req_ready_1(req_ready1[gi]),
      .i_arg_A_0(arg_a0[gi]), .i_arg_B_0(arg_b0[gi]),
      .i_arg_A_1(arg_a1[gi]), .i_arg_B_1(arg_b1[gi]),
      .i_op_0(op0[gi]), .i_op_1(op1[gi]),
      .o_rsp_valid_0(rsp_valid0[gi]), .o_rsp_valid_1(rsp_valid1[gi]),
      .i_rsp_ready_0(rsp_ready0[gi]), .i_rsp_ready_1(rsp_ready1[gi]),
      .o_rsp_result(rsp_result[gi]), .o_rsp_status(rsp_status[gi]),
      .o_alu_arg_A(alu_a[gi]), .o_alu_arg_B(alu_b[gi]), .o_alu_op(alu_op[gi]),
      .i_alu_result(alu_result[gi]), .i_alu_status(alu_status[gi]),
      .o_busy(busy[gi]), .o_grant_id(grant[gi]), .o_txn_count(txn_count[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input int d);
    chk("rst_ready0", 32'(req_ready0[d]), 32'd0);
    chk("rst_ready1", 32'(req_ready1[d]), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid0[d] | rsp_valid1[d]), 32'd0);
    chk("rst_result", rsp_result[d], 32'd0);
    chk("rst_status", 32'(rsp_status[d]), 32'd0);
    chk("rst_alu_a", alu_a[d], 32'd0);
    chk("rst_alu_b", alu_b[d], 32'd0);
    chk("rst_alu_op", 32'(alu_op[d]), 32'd0);
    chk("rst_busy", 32'(busy[d]), 32'd0);
    chk("rst_grant", 32'(grant[d]), 32'd0);
    chk("rst_txn", 32'(txn_count[d]), 32'd0);
  endtask

  // One full transaction: present request(s), act as the unit, apply backpressure, retire.
  task automatic issue(input int d, input bit v0, input bit v1,
                       input logic [31:0] a0, input logic [31:0] b0, input logic [1:0] o0,
                       input logic [31:0] a1, input logic [31:0] b1, input logic [1:0] o1,
                       input bit gid, input logic [31:0] res, input logic [3:0] st,
                       input int hold);
    int   lat;
    int   n;
    exp_t e;
    lat = (d == 0) ? 1 : 4;
    req_valid0[d] = v0; req_valid1[d] = v1;
    arg_a0[d] = a0; arg_b0[d] = b0; op0[d] = o0;
    arg_a1[d] = a1; arg_b1[d] = b1; op1[d] = o1;
    alu_result[d] = 32'hBAD0_0000; alu_status[d] = 4'hF;
    #1;
    n = 0;
    while (!(req_ready0[d] || req_ready1[d]) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("accept_seen", 32'(n < 20), 32'd1);
    chk("grant_ready0", 32'(req_ready0[d]), 32'(!gid));
    chk("grant_ready1", 32'(req_ready1[d]), 32'(gid));
    e.gid = gid; e.res = res; e.st = st;
    e.a = gid ? a1 : a0; e.b = gid ? b1 : b0; e.op = gid ? o1 : o0;
    if (d == 0) sb0.push_back(e); else sb1.push_back(e);
    @(posedge clk);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      chk("wait_no_rsp", 32'(rsp_valid0[d] | rsp_valid1[d]), 32'd0);
      chk("wait_no_ready", 32'(req_ready0[d] | req_ready1[d]), 32'd0);
      chk("wait_busy", 32'(busy[d]), 32'd1);
      if (c == 1) begin
        chk("alu_a_t1", alu_a[d], e.a);
        chk("alu_b_t1", alu_b[d], e.b);
        chk("grant_id", 32'(grant[d]), 32'(gid));
      end
      alu_result[d] = (c == lat) ? res : (32'hBAD0_0000 + 32'(c));
      alu_status[d] = (c == lat) ? st : 4'hF;
    end
    @(negedge clk);
    chk("rsp_valid_win", 32'(gid ? rsp_valid1[d] : rsp_valid0[d]), 32'd1);
    chk("rsp_valid_other", 32'(gid ? rsp_valid0[d] : rsp_valid1[d]), 32'd0);
    for (int h = 0; h < hold; h++) begin
      alu_result[d] = 32'hDEADBEEF ^ 32'(h);
      alu_status[d] = ~st;
      if (gid) begin rsp_ready1[d] = 1'b0; rsp_ready0[d] = 1'b1; end
      else     begin rsp_ready0[d] = 1'b0; rsp_ready1[d] = 1'b1; end
      @(negedge clk);
      chk("hold_result", rsp_result[d], res);
      chk("hold_status", 32'(rsp_status[d]), 32'(st));
      chk("hold_no_ready", 32'(req_ready0[d] | req_ready1[d]), 32'd0);
      chk("hold_busy", 32'(busy[d]), 32'd1);
      chk("hold_valid", 32'(gid ? rsp_valid1[d] : rsp_valid0[d]), 32'd1);
    end
    rsp_ready0[d] = !gid; rsp_ready1[d] = gid;
    @(posedge clk);
    @(negedge clk);
    rsp_ready0[d] = 1'b0; rsp_ready1[d] = 1'b0;
    txn_exp[d] = txn_exp[d] + 16'd1;
    chk("retire_idle", 32'(busy[d]), 32'd0);
    chk("retire_no_rsp", 32'(rsp_valid0[d] | rsp_valid1[d]), 32'd0);
    chk("txn_count", 32'(txn_count[d]), 32'(txn_exp[d]));
  endtask

  // Monitor: invariants every cycle, scoreboard pop on each response handshake.
  always @(negedge clk) begin
    #3;
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        exp_t e;
        bit   empty;
        chk("ready_onehot", 32'(req_ready0[d] & req_ready1[d]), 32'd0);
        chk("rsp_onehot", 32'(rsp_valid0[d] & rsp_valid1[d]), 32'd0);
        chk("ready_idle_only", 32'(busy[d] & (req_ready0[d] | req_ready1[d])), 32'd0);
        if ((rsp_valid0[d] && rsp_ready0[d]) || (rsp_valid1[d] && rsp_ready1[d])) begin
          empty = (d == 0) ? (sb0.size() == 0) : (sb1.size() == 0);
          chk("sb_nonempty", 32'(empty), 32'd0);
          if (!empty) begin
            if (d == 0) e = sb0.pop_front(); else e = sb1.pop_front();
            chk("sb_gid", 32'(grant[d]), 32'(e.gid));
            chk("sb_valid_port", 32'(rsp_valid1[d]), 32'(e.gid));
            chk("sb_result", rsp_result[d], e.res);
            chk("sb_status", 32'(rsp_status[d]), 32'(e.st));
            chk("sb_alu_a", alu_a[d], e.a);
            chk("sb_alu_b", alu_b[d], e.b);
            chk("sb_alu_op", 32'(alu_op[d]), 32'(e.op));
            $display("txn dut%0d gid=%0d A=%h B=%h op=%0d result=%h status=%h",
                     d, grant[d], alu_a[d], alu_b[d], alu_op[d], rsp_result[d], rsp_status[d]);
          end
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req_valid0[d] = 1'b1; req_valid1[d] = 1'b1;
      arg_a0[d] = 32'd5; arg_b0[d] = 32'd3; op0[d] = 2'd1;
      arg_a1[d] = 32'd10; arg_b1[d] = 32'd4; op1[d] = 2'd2;
      rsp_ready0[d] = 1'b0; rsp_ready1[d] = 1'b0;
      alu_result[d] = '0; alu_status[d] = '0; txn_exp[d] = '0;
    end
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      for (int d = 0; d < 2; d++) check_zero(d);
    end
    mon_en = 1'b1;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("first_grant_r0", 32'(req_ready0[d]), 32'd1);
      chk("first_grant_r1", 32'(req_ready1[d]), 32'd0);
    end
    req_valid0[1] = 1'b0; req_valid1[1] = 1'b0;

    // LATENCY=1: contention alternates 0,1,0,1
    issue(0, 1'b1, 1'b1, 32'd5, 32'd3, 2'd1, 32'd10, 32'd4, 2'd2, 1'b0, 32'd8, 4'h0, 0);
    issue(0, 1'b1, 1'b1, 32'd7, 32'd2, 2'd0, 32'd10, 32'd4, 2'd2, 1'b1, 32'd6, 4'h1, 1);
    issue(0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'd1, 2'd1, 32'd10, 32'd4, 2'd2, 1'b0, 32'd0, 4'h4, 0);
    issue(0, 1'b1, 1'b1, 32'd9, 32'd9, 2'd0, 32'h80000000, 32'd1, 2'd3, 1'b1, 32'h7FFFFFFF, 4'h2, 2);
    chk("contention_txn4", 32'(txn_count[0]), 32'd4);
    // single requester with 5 cycles of backpressure
    issue(0, 1'b1, 1'b0, 32'd5, 32'd3, 2'd1, 32'd0, 32'd0, 2'd0, 1'b0, 32'd8, 4'h0, 5);
    // lone requesters win regardless of the pointer
    issue(0, 1'b1, 1'b0, 32'd1, 32'd2, 2'd3, 32'd0, 32'd0, 2'd0, 1'b0, 32'h12345678, 4'h8, 0);
    issue(0, 1'b0, 1'b1, 32'd0, 32'd0, 2'd0, 32'd40, 32'd2, 2'd2, 1'b1, 32'd20, 4'h0, 0);
    issue(0, 1'b0, 1'b1, 32'd0, 32'd0, 2'd0, 32'd6, 32'd7, 2'd2, 1'b1, 32'd42, 4'h0, 0);

    // counter wraparound from 0xFFFF
    req_valid0[0] = 1'b0; req_valid1[0] = 1'b0;
    force g_dut[0].u_dut.txn_q = 16'hFFFF;
    @(negedge clk);
    release g_dut[0].u_dut.txn_q;
    @(negedge clk);
    chk("preload_txn", 32'(txn_count[0]), 32'h0000FFFF);
    txn_exp[0] = 16'hFFFF;
    issue(0, 1'b1, 1'b0, 32'd3, 32'd3, 2'd0, 32'd0, 32'd0, 2'd0, 1'b0, 32'd6, 4'h0, 0);
    chk("wrap_txn_zero", 32'(txn_count[0]), 32'd0);
    req_valid0[0] = 1'b0; req_valid1[0] = 1'b0;

    // LATENCY=4: garbage on the unit result before T+4 must never be captured
    issue(1, 1'b1, 1'b1, 32'd100, 32'd23, 2'd0, 32'd1, 32'd1, 2'd0, 1'b0, 32'd123, 4'h0, 0);
    issue(1, 1'b0, 1'b1, 32'd0, 32'd0, 2'd0, 32'hDEAD0000, 32'h0000BEEF, 2'd2, 1'b1, 32'hDEADBEEF, 4'h8, 3);

    // reset while in WAIT drops the transaction
    req_valid0[1] = 1'b1; req_valid1[1] = 1'b0;
    arg_a0[1] = 32'd77; arg_b0[1] = 32'd11; op0[1] = 2'd1;
    #1;
    chk("rstwait_accept", 32'(req_ready0[1]), 32'd1);
    @(posedge clk); @(negedge clk);
    req_valid0[1] = 1'b0;
    chk("rstwait_busy", 32'(busy[1]), 32'd1);
    rst_n[1] = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n[1] = 1'b1;
    check_zero(1);
    rsp_ready0[1] = 1'b1; rsp_ready1[1] = 1'b1;
    alu_result[1] = 32'h55555555;
    repeat (8) begin
      @(negedge clk);
      chk("rstwait_no_rsp", 32'(rsp_valid0[1] | rsp_valid1[1]), 32'd0);
    end
    rsp_ready0[1] = 1'b0; rsp_ready1[1] = 1'b0;
    chk("rstwait_txn", 32'(txn_count[1]), 32'd0);
    txn_exp[1] = 16'd0;
    // pointer returned to requester 0 by reset
    issue(1, 1'b1, 1'b1, 32'd8, 32'd8, 2'd0, 32'd9, 32'd9, 2'd0, 1'b0, 32'd16, 4'h0, 0);
    req_valid0[1] = 1'b0; req_valid1[1] = 1'b0;

    repeat (4) @(negedge clk);
    chk("sb0_drained", 32'(sb0.size()), 32'd0);
    chk("sb1_drained", 32'(sb1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_arith_arbiter.md
Name: sync_arith_arbiter

Overview:
Two-port round-robin arbiter and sequencer that shares one synchronous arithmetic unit (BITS-wide operands, 2-bit op, BITS-wide result, 4-bit status) between two requesters. It accepts one operation at a time over a valid/ready handshake and drives the unit's operand and op inputs. It waits a fixed unit latency, captures the result and status, and returns them to the winning requester over a valid/ready response handshake. It sits between client blocks and the arithmetic unit instance.

Parameters:
BITS, 32, operand/result width
LATENCY, 1, clock edges from operands stable on o_alu_* to i_alu_result/i_alu_status valid (1..15)

Ports:
i_clk  input  1  clock, rising-edge
i_reset  input  1  synchronous reset, active-low
i_req_valid_0 / i_req_valid_1  input  1  requester k has an operation
o_req_ready_0 / o_req_ready_1  output  1  arbiter accepts requester k this cycle
i_arg_A_0, i_arg_B_0 / i_arg_A_1, i_arg_B_1  input  BITS  operands of requester k
i_op_0 / i_op_1  input  2  op code of requester k, passed through unmodified
o_rsp_valid_0 / o_rsp_valid_1  output  1  response for requester k available
i_rsp_ready_0 / i_rsp_ready_1  input  1  requester k takes response
o_rsp_result  output  BITS  captured result, shared by both requesters
o_rsp_status  output  4  captured status, shared by both requesters
o_alu_arg_A, o_alu_arg_B  output  BITS  operands to the arithmetic unit
o_alu_op  output  2  op to the arithmetic unit
i_alu_result  input  BITS  unit result
i_alu_status  input  4  unit status
o_busy  output  1  high in any state other than IDLE
o_grant_id  output  1  requester owning the current or last transaction
o_txn_count  output  16  completed transactions (response handshakes), wraps at 0xFFFF→0

Behaviour:
- Reset:
  - Takes effect when i_reset=0 at a rising edge; i_reset is sampled only at clock edges.
  - Next state is IDLE.
  - All outputs and registers become 0, including o_alu_*, o_rsp_*, o_txn_count and o_grant_id.
  - The round-robin pointer is set so requester 0 wins the next tie.
  - A reset mid-transaction drops that transaction; no response is issued.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - o_req_ready_k = winner_k (combinational from i_req_valid_*).
  - If only one requester is valid, it wins.
  - If both are valid, the requester not granted last wins (round-robin).
  - Ready is never high outside IDLE, and never for both requesters at once.
  - On handshake (valid&&ready at edge T):
    - latch A/B/op into o_alu_*;
    - set o_grant_id=k;
    - load wait counter with LATENCY;
    - go to WAIT.
- WAIT:
  - o_alu_* are stable from T+1 until the next accept.
  - The counter decrements each edge.
  - When the counter reaches 1, capture i_alu_result/i_alu_status into o_rsp_result/o_rsp_status and go to RESP.
  - Capture therefore occurs at edge T+LATENCY.
- RESP:
  - o_rsp_valid_{grant_id}=1, other o_rsp_valid=0.
  - o_rsp_result/o_rsp_status are held until the response handshake.
  - On i_rsp_ready_{grant_id}=1:
    - increment o_txn_count;
    - flip the round-robin pointer to favour the other requester;
    - go to IDLE.
  - i_rsp_ready of the non-granted requester is ignored.
- Response timing: first o_rsp_valid cycle is LATENCY cycles after the accept edge.
- Minimum issue interval: LATENCY+2 cycles per transaction; there is no accept in the cycle a response retires.
- Requester inputs are don't-care except while being accepted.
- Arithmetic: no width changes; operands, op and results pass through bit-exact.

Test Plan:
1. Reset: hold i_reset=0 for 2 edges with both valids high → o_req_ready_*=0 during reset, all outputs 0; after release, requester 0 is granted first.
2. Single request, LATENCY=1: req0 A=5, B=3, op=2'b01 accepted at edge T; bench drives i_alu_result=8, i_alu_status=4'b0000 → o_alu_arg_A=5 and o_alu_arg_B=3 from T+1; o_rsp_valid_0=1 with result 8 from T+1; i_rsp_ready_0=1 → o_txn_count=1, back in IDLE.
3. Contention: both valid continuously for 4 transactions → grants alternate 0,1,0,1; o_txn_count=4; o_rsp_valid_1 is never high during a requester-0 transaction.
4. Backpressure: hold i_rsp_ready_0=0 for 5 cycles in RESP while i_alu_result changes to 0xDEADBEEF → o_rsp_result stays 8, o_req_ready_*=0 throughout, o_busy=1.
5. LATENCY=4: accept at edge T → capture at edge T+4; i_alu_result values present before T+4 are never visible on o_rsp_result.
6. Reset in WAIT, then wraparound: drive i_reset=0 in WAIT → no o_rsp_valid afterwards, o_txn_count=0. Separately, preload 0xFFFF completions → next completion gives o_txn_count=0.
